egress_mem_arbiter: RTL and testbench

Shares the single packet-memory read interface among NUM_PORTS egress blocks. Each egress port's start/read requests are latched and granted round-robin, one frame at a time. The owner holds the memory until frame_end. The returned block data is broadcast to all ports, with valid/end qualified to the owner only. Sits between the per-port egress instances and the packet memory read controller.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/egress_mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_egress_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and helpers for the egress memory arbiter.
//                Holds the arbiter state encoding, default geometry of the
//                packet-memory interface and the port-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    // Default packet-memory geometry.
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_BLOCK_BYTES = 4;

    // Width of a port index (owner, rr_ptr); never below one bit.
    function automatic int port_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Returns the first set
//                request bit at or after rr_ptr, wrapping at N-1.
//  Ports       : req         - request vector
//                rr_ptr      - highest-priority index this round
//                grant_valid - any request set
//                grant       - index of the winning request
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = port_idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant
);

    int           w_idx;
    logic [N-1:0] w_hit;

    // Scan from the farthest candidate to the nearest so the one closest
    // to rr_ptr is the last assignment and therefore wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        w_idx       = 0;
        w_hit       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = int'(rr_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            w_hit = req >> w_idx;
            if (w_hit[0]) begin
                grant_valid = 1'b1;
                grant       = IDX_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/egress_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : egress_mem_arbiter
//  Description : Shares the packet-memory read interface among NUM_PORTS
//                egress blocks. Start requests are latched per port and
//                granted round-robin one frame at a time; the owner keeps
//                the memory until frame_end. Read data is broadcast, with
//                valid/end qualified to the owner.
//  Ports       : switch_clk/switch_rst - clock, sync active-high reset
//                req_*_i / req_*_o     - per-port egress request side
//                frame_*_o             - per-port return path
//                mem_*_o, flood_o      - memory read controller command
//                frame_*_i             - memory read data return
//  Revision    : 1.0 - initial release
// ============================================================================
module egress_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int BLOCK_BYTES = DEF_BLOCK_BYTES
) (
    input  logic                              switch_clk,
    input  logic                              switch_rst,
    input  logic [NUM_PORTS-1:0]              req_start_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]       req_addr_i,
    input  logic [NUM_PORTS-1:0]              req_flood_i,
    input  logic [NUM_PORTS-1:0]              req_re_i,
    output logic [NUM_PORTS-1:0]              req_ready_o,
    output logic [NUM_PORTS-1:0]              req_drop_o,
    output logic [BLOCK_BYTES*DATA_WIDTH-1:0] frame_data_o,
    output logic [NUM_PORTS-1:0]              frame_valid_o,
    output logic [NUM_PORTS-1:0]              frame_end_o,
    output logic                              mem_re_o,
    output logic                              mem_start_o,
    output logic [ADDR_W-1:0]                 mem_start_addr_o,
    output logic                              flood_o,
    input  logic [BLOCK_BYTES*DATA_WIDTH-1:0] frame_data_i,
    input  logic                              frame_valid_i,
    input  logic                              frame_end_i
);

    localparam int               IDX_W       = port_idx_w(NUM_PORTS);
    localparam logic [IDX_W-1:0] C_LAST_PORT = IDX_W'(NUM_PORTS - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_next;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [NUM_PORTS-1:0] r_pending;
    logic [NUM_PORTS-1:0] r_drop;
    logic [NUM_PORTS-1:0] r_flood;
    logic [ADDR_W-1:0]    r_addr [NUM_PORTS];

    logic [NUM_PORTS-1:0] w_ready;
    logic                 w_grant_valid;
    logic [IDX_W-1:0]     w_grant;
    logic                 w_take;
    logic                 w_frame_done;
    logic [IDX_W-1:0]     w_owner_next;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req         (r_pending),
        .rr_ptr      (r_rr_ptr),
        .grant_valid (w_grant_valid),
        .grant       (w_grant)
    );

    assign w_take       = (r_state == IDLE) && w_grant_valid;
    assign w_frame_done = (r_state == BUSY) && frame_valid_i && frame_end_i;
    // Explicit wrap so non-power-of-2 port counts never produce an
    // out-of-range pointer.
    assign w_owner_next = (r_owner == C_LAST_PORT) ? '0 : r_owner + 1'b1;

    // The owner is busy for the whole grant, so it cannot queue its next
    // frame until it has released the memory.
    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
            assign w_ready[i]       = ~r_pending[i]
                                    & ~((r_state != IDLE) && (r_owner == IDX_W'(i)));
            assign frame_valid_o[i] = frame_valid_i && (r_state == BUSY)
                                    && (r_owner == IDX_W'(i));
            assign frame_end_o[i]   = frame_end_i && (r_state == BUSY)
                                    && (r_owner == IDX_W'(i));
        end
    endgenerate

    assign req_ready_o  = w_ready;
    assign req_drop_o   = r_drop;
    assign frame_data_o = frame_data_i;

    // Request latches. A granted port always has pending set, so it can
    // never be ready in the same cycle its pending bit is cleared.
    always_ff @(posedge switch_clk) begin
        if (switch_rst) begin
            r_pending <= '0;
            r_drop    <= '0;
            r_flood   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (req_start_i[i]) begin
                    if (w_ready[i]) begin
                        r_pending[i] <= 1'b1;
                        r_addr[i]    <= req_addr_i[i*ADDR_W +: ADDR_W];
                        r_flood[i]   <= req_flood_i[i];
                    end else begin
                        r_drop[i]    <= 1'b1;
                    end
                end
            end
            if (w_take) begin
                r_pending[w_grant] <= 1'b0;
            end
        end
    end

    // Owner and rotation pointer. The releasing port moves to the back of
    // the queue for the next arbitration.
    always_ff @(posedge switch_clk) begin
        if (switch_rst) begin
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_take) begin
                r_owner <= w_grant;
            end
            if (w_frame_done) begin
                r_rr_ptr <= w_owner_next;
            end
        end
    end

    always_ff @(posedge switch_clk) begin
        if (switch_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        mem_start_o      = 1'b0;
        mem_re_o         = 1'b0;
        mem_start_addr_o = '0;
        flood_o          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = START;
                end
            end
            START: begin
                mem_start_o      = 1'b1;
                mem_start_addr_o = r_addr[r_owner];
                flood_o          = r_flood[r_owner];
                w_state_next     = BUSY;
            end
            BUSY: begin
                mem_re_o         = req_re_i[r_owner];
                mem_start_addr_o = r_addr[r_owner];
                flood_o          = r_flood[r_owner];
                if (frame_valid_i && frame_end_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_egress_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_egress_mem_arbiter
//  Description : Directed self-checking bench for egress_mem_arbiter
//                (4 ports, 8-bit pointers, 32-bit block data).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_egress_mem_arbiter;

    logic        switch_clk = 1'b0;
    logic        switch_rst;
    logic [3:0]  req_start_i;
    logic [31:0] req_addr_i;
    logic [3:0]  req_flood_i;
    logic [3:0]  req_re_i;
    logic [3:0]  req_ready_o;
    logic [3:0]  req_drop_o;
    logic [31:0] frame_data_o;
    logic [3:0]  frame_valid_o;
    logic [3:0]  frame_end_o;
    logic        mem_re_o;
    logic        mem_start_o;
    logic [7:0]  mem_start_addr_o;
    logic        flood_o;
    logic [31:0] frame_data_i;
    logic        frame_valid_i;
    logic        frame_end_i;

    int n_tests = 0;
    int n_fail  = 0;

    egress_mem_arbiter #(
        .NUM_PORTS   (4),
        .ADDR_W      (8),
        .DATA_WIDTH  (8),
        .BLOCK_BYTES (4)
    ) dut (
        .switch_clk       (switch_clk),
        .switch_rst       (switch_rst),
        .req_start_i      (req_start_i),
        .req_addr_i       (req_addr_i),
        .req_flood_i      (req_flood_i),
        .req_re_i         (req_re_i),
        .req_ready_o      (req_ready_o),
        .req_drop_o       (req_drop_o),
        .frame_data_o     (frame_data_o),
        .frame_valid_o    (frame_valid_o),
        .frame_end_o      (frame_end_o),
        .mem_re_o         (mem_re_o),
        .mem_start_o      (mem_start_o),
        .mem_start_addr_o (mem_start_addr_o),
        .flood_o          (flood_o),
        .frame_data_i     (frame_data_i),
        .frame_valid_i    (frame_valid_i),
        .frame_end_i      (frame_end_i)
    );

    always #5 switch_clk = ~switch_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge switch_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [7:0] a, input logic fl);
        req_addr_i[p*8 +: 8] = a;
        req_flood_i[p]       = fl;
    endtask

    // Entered in the START cycle of a grant; runs a one-block frame and
    // returns in the idle cycle that follows frame_end.
    task automatic expect_grant(input string tag, input logic [3:0] own,
                                input logic [7:0] addr, input logic fl);
        chk({tag, "_start"}, {31'd0, mem_start_o}, 32'd1);
        chk({tag, "_addr"},  {24'd0, mem_start_addr_o}, {24'd0, addr});
        chk({tag, "_flood"}, {31'd0, flood_o}, {31'd0, fl});
        step();
        frame_valid_i = 1'b1;
        frame_end_i   = 1'b1;
        settle();
        chk({tag, "_valid"}, {28'd0, frame_valid_o}, {28'd0, own});
        chk({tag, "_end"},   {28'd0, frame_end_o},   {28'd0, own});
        step();
        frame_valid_i = 1'b0;
        frame_end_i   = 1'b0;
        settle();
        chk({tag, "_idle"}, {31'd0, mem_start_o}, 32'd0);
    endtask

    initial begin
        switch_rst    = 1'b1;
        req_start_i   = '0;
        req_addr_i    = '0;
        req_flood_i   = '0;
        req_re_i      = '0;
        frame_data_i  = '0;
        frame_valid_i = 1'b0;
        frame_end_i   = 1'b0;
        step();
        step();
        switch_rst = 1'b0;
        settle();

        // ---------------- reset state ----------------
        chk("rst_ready", {28'd0, req_ready_o}, 32'hF);
        chk("rst_drop",  {28'd0, req_drop_o}, 32'h0);
        chk("rst_start", {31'd0, mem_start_o}, 32'd0);
        chk("rst_re",    {31'd0, mem_re_o}, 32'd0);
        chk("rst_addr",  {24'd0, mem_start_addr_o}, 32'd0);
        chk("rst_valid", {28'd0, frame_valid_o}, 32'd0);

        // ---------------- single request, port 2 ----------------
        set_port(2, 8'h15, 1'b1);
        req_start_i = 4'b0100;
        settle();
        chk("s_ready_t", {28'd0, req_ready_o}, 32'hF);
        step();
        req_start_i = '0;
        settle();
        chk("s_ready_t1", {28'd0, req_ready_o}, 32'hB);
        chk("s_start_t1", {31'd0, mem_start_o}, 32'd0);
        step();
        req_re_i = 4'b0100;
        settle();
        chk("s_start",   {31'd0, mem_start_o}, 32'd1);
        chk("s_addr",    {24'd0, mem_start_addr_o}, 32'h15);
        chk("s_flood",   {31'd0, flood_o}, 32'd1);
        chk("s_re_strt", {31'd0, mem_re_o}, 32'd0);
        step();
        settle();
        chk("s_re_own",  {31'd0, mem_re_o}, 32'd1);
        req_re_i = 4'b0001;
        settle();
        chk("s_re_other", {31'd0, mem_re_o}, 32'd0);
        frame_data_i  = 32'hDEADBEEF;
        frame_valid_i = 1'b1;
        settle();
        chk("s_valid",   {28'd0, frame_valid_o}, 32'h4);
        chk("s_end0",    {28'd0, frame_end_o}, 32'h0);
        chk("s_data",    frame_data_o, 32'hDEADBEEF);
        chk("s_addr_bz", {24'd0, mem_start_addr_o}, 32'h15);
        step();
        frame_end_i = 1'b1;
        settle();
        chk("s_end",     {28'd0, frame_end_o}, 32'h4);
        step();
        // Stray data while idle must not reach any port.
        req_re_i = 4'b0100;
        settle();
        chk("i_valid", {28'd0, frame_valid_o}, 32'h0);
        chk("i_end",   {28'd0, frame_end_o}, 32'h0);
        chk("i_re",    {31'd0, mem_re_o}, 32'd0);
        chk("i_addr",  {24'd0, mem_start_addr_o}, 32'h0);
        chk("i_flood", {31'd0, flood_o}, 32'd0);
        chk("i_ready", {28'd0, req_ready_o}, 32'hF);
        frame_valid_i = 1'b0;
        frame_end_i   = 1'b0;
        req_re_i      = '0;
        req_flood_i   = '0;

        switch_rst = 1'b1;
        step();
        switch_rst = 1'b0;

        // ---------------- contention 0,1,3 with rr_ptr=0 ----------------
        set_port(0, 8'h10, 1'b0);
        set_port(1, 8'h11, 1'b0);
        set_port(3, 8'h13, 1'b0);
        req_start_i = 4'b1011;
        step();
        req_start_i = '0;
        settle();
        chk("c_ready", {28'd0, req_ready_o}, 32'h4);
        step();
        expect_grant("c0", 4'b0001, 8'h10, 1'b0);
        step();
        expect_grant("c1", 4'b0010, 8'h11, 1'b0);
        step();
        expect_grant("c3", 4'b1000, 8'h13, 1'b0);

        // ---------------- fairness: 0 and 1 alternate ----------------
        set_port(0, 8'h20, 1'b0);
        set_port(1, 8'h21, 1'b0);
        req_start_i = 4'b0011;
        step();
        req_start_i = '0;
        step();
        expect_grant("f0", 4'b0001, 8'h20, 1'b0);
        set_port(0, 8'h22, 1'b0);
        req_start_i = 4'b0001;
        step();
        req_start_i = '0;
        expect_grant("f1", 4'b0010, 8'h21, 1'b0);
        set_port(1, 8'h23, 1'b0);
        req_start_i = 4'b0010;
        step();
        req_start_i = '0;
        expect_grant("f2", 4'b0001, 8'h22, 1'b0);
        step();
        expect_grant("f3", 4'b0010, 8'h23, 1'b0);

        // ---------------- rotation: rr_ptr=2, ports 0 and 3 ----------------
        set_port(0, 8'h30, 1'b0);
        set_port(3, 8'h33, 1'b1);
        req_start_i = 4'b1001;
        step();
        req_start_i = '0;
        step();
        expect_grant("r3", 4'b1000, 8'h33, 1'b1);
        step();
        expect_grant("r0", 4'b0001, 8'h30, 1'b0);

        // ---------------- drop on pulse while pending ----------------
        set_port(1, 8'h41, 1'b0);
        req_start_i = 4'b0010;
        step();
        set_port(1, 8'h42, 1'b0);
        settle();
        chk("d_drop_pre", {28'd0, req_drop_o}, 32'h0);
        step();
        req_start_i = '0;
        settle();
        chk("d_drop", {28'd0, req_drop_o}, 32'h2);
        expect_grant("d1", 4'b0010, 8'h41, 1'b0);
        chk("d_drop_sticky", {28'd0, req_drop_o}, 32'h2);

        // ---------------- reset in the middle of BUSY ----------------
        set_port(2, 8'h55, 1'b1);
        req_start_i = 4'b0100;
        step();
        req_start_i = '0;
        step();
        step();
        req_re_i      = 4'b0100;
        frame_valid_i = 1'b1;
        set_port(0, 8'h60, 1'b0);
        req_start_i   = 4'b0001;
        settle();
        chk("m_re",    {31'd0, mem_re_o}, 32'd1);
        chk("m_valid", {28'd0, frame_valid_o}, 32'h4);
        step();
        req_start_i = '0;
        switch_rst  = 1'b1;
        step();
        switch_rst  = 1'b0;
        settle();
        chk("m_rst_valid", {28'd0, frame_valid_o}, 32'h0);
        chk("m_rst_re",    {31'd0, mem_re_o}, 32'd0);
        chk("m_rst_start", {31'd0, mem_start_o}, 32'd0);
        chk("m_rst_addr",  {24'd0, mem_start_addr_o}, 32'h0);
        chk("m_rst_flood", {31'd0, flood_o}, 32'd0);
        chk("m_rst_ready", {28'd0, req_ready_o}, 32'hF);
        chk("m_rst_drop",  {28'd0, req_drop_o}, 32'h0);
        frame_valid_i = 1'b0;
        req_re_i      = '0;
        step();
        settle();
        chk("m_no_pending", {31'd0, mem_start_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
